// File: rtl/pixel_filter_pkg.sv
// Shared types and helpers for the image filter path.
package pixel_filter_pkg;

    localparam int PIX_W = 8;

    typedef enum logic {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } acc_state_t;

    // Number of bits needed to count 0..win-1 (win is a power of two).
    function automatic int clog2_win(input int win);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < win) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/N_fulladder_module.sv
// Team N-bit ripple-carry adder built from a chain of full-adder cells.
module N_fulladder_module #(
    parameter int N = 8
) (
    input  logic [N-1:0] a_i,
    input  logic [N-1:0] b_i,
    input  logic         cin_i,
    output logic [N-1:0] sum_o,
    output logic         cout_o
);

    logic carry_s;

    // Ripple the carry through one full-adder cell per bit.
    always_comb begin
        carry_s = cin_i;
        sum_o   = '0;
        for (int i = 0; i < N; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ carry_s;
            carry_s  = (a_i[i] & b_i[i]) | (carry_s & (a_i[i] ^ b_i[i]));
        end
        cout_o = carry_s;
    end

endmodule

// File: rtl/pixel_box_accumulator_chk.sv
// Runtime properties for pixel_box_accumulator.
module pixel_box_accumulator_chk (
    input logic clk,
    input logic rst_n,
    input logic carry_i
);

    // The accumulator is sized so the adder can never carry out.
    a_no_carry: assert property (@(posedge clk) disable iff (!rst_n) !carry_i)
        else $error("adder carry-out set");

endmodule

// File: rtl/pixel_box_accumulator.sv
// Valid/ready box accumulator: sums WIN pixels and emits the sum plus the
// round-half-up mean, with full-rate back-to-back windows.
module pixel_box_accumulator
    import pixel_filter_pkg::*;
#(
    parameter  int DATA_W = PIX_W,
    parameter  int WIN    = 4,
    localparam int CNT_W  = clog2_win(WIN),
    localparam int ACC_W  = DATA_W + CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_mean
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);
    localparam logic [ACC_W-1:0] RND_HALF = ACC_W'(WIN / 2);

    acc_state_t        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  out_sum_q, out_sum_d;
    logic [DATA_W-1:0] out_mean_q, out_mean_d;

    logic              accept_s;
    logic              xfer_s;
    logic [ACC_W-1:0]  add_a_s;
    logic [ACC_W-1:0]  pix_ext_s;
    logic [ACC_W-1:0]  add_sum_s;
    logic              add_cout_s;
    logic [ACC_W-1:0]  rnd_s;

    // A window restarted from OUTPUT begins from zero rather than acc_q.
    assign add_a_s   = (state_q == OUTPUT) ? '0 : acc_q;
    assign pix_ext_s = {{CNT_W{1'b0}}, in_pixel};
    assign accept_s  = in_valid & in_ready;
    assign xfer_s    = out_valid & out_ready;
    assign rnd_s     = add_sum_s + RND_HALF;

    N_fulladder_module #(.N(ACC_W)) u_adder (
        .a_i    (add_a_s),
        .b_i    (pix_ext_s),
        .cin_i  (1'b0),
        .sum_o  (add_sum_s),
        .cout_o (add_cout_s)
    );

    pixel_box_accumulator_chk u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .carry_i (add_cout_s)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            out_sum_q  <= '0;
            out_mean_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            out_sum_q  <= out_sum_d;
            out_mean_q <= out_mean_d;
        end
    end

    // Next-state and datapath update; clear overrides everything.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        out_sum_d  = out_sum_q;
        out_mean_d = out_mean_q;
        if (clear) begin
            state_d    = ACCUM;
            acc_d      = '0;
            cnt_d      = '0;
            out_sum_d  = '0;
            out_mean_d = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept_s && (cnt_q == CNT_LAST)) begin
                        out_sum_d  = add_sum_s;
                        out_mean_d = DATA_W'(rnd_s >> CNT_W);
                        acc_d      = '0;
                        cnt_d      = '0;
                        state_d    = OUTPUT;
                    end else if (accept_s) begin
                        acc_d = add_sum_s;
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        acc_d = acc_q;
                    end
                end
                OUTPUT: begin
                    if (xfer_s && accept_s) begin
                        acc_d   = add_sum_s;
                        cnt_d   = CNT_W'(1);
                        state_d = ACCUM;
                    end else if (xfer_s) begin
                        state_d = ACCUM;
                    end else begin
                        state_d = OUTPUT;
                    end
                end
                default: begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Handshake outputs decoded from the registered state.
    always_comb begin
        out_valid = 1'b0;
        in_ready  = 1'b1;
        case (state_q)
            ACCUM: begin
                out_valid = 1'b0;
                in_ready  = 1'b1;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
                out_valid = 1'b0;
                in_ready  = 1'b0;
            end
        endcase
    end

    assign out_sum  = out_sum_q;
    assign out_mean = out_mean_q;

endmodule

// File: tb/tb_pixel_box_accumulator.sv
// Directed, table-driven bench for pixel_box_accumulator (DATA_W=8, WIN=4).
module tb_pixel_box_accumulator;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pixel;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] out_sum;
    logic [7:0] out_mean;

    int total;
    int bad;

    typedef struct packed {
        logic [3:0][7:0] px;
        logic [9:0]      sum;
        logic [7:0]      mean;
    } vec_t;

    vec_t vecs [7];

    pixel_box_accumulator #(.DATA_W(8), .WIN(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pixel  (in_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_mean  (out_mean)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [7:0] p0, input logic [7:0] p1,
                                input logic [7:0] p2, input logic [7:0] p3,
                                input logic [9:0] s, input logic [7:0] m);
        vec_t v;
        v.px[0] = p0;
        v.px[1] = p1;
        v.px[2] = p2;
        v.px[3] = p3;
        v.sum   = s;
        v.mean  = m;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic feed(input logic [7:0] px);
        @(negedge clk);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);
        in_valid = 1'b1;
        in_pixel = px;
    endtask

    task automatic expect_result(input string nm, input logic [9:0] s, input logic [7:0] m);
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
        chk({nm, "_sum"}, {22'd0, out_sum}, {22'd0, s});
        chk({nm, "_mean"}, {24'd0, out_mean}, {24'd0, m});
        @(negedge clk);
        chk({nm, "_drop"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        clear     = 1'b0;
        in_valid  = 1'b0;
        in_pixel  = 8'd0;
        out_ready = 1'b1;

        vecs[0] = mk(8'd10,  8'd20,  8'd30,  8'd40,  10'd100,  8'd25);
        vecs[1] = mk(8'd255, 8'd255, 8'd255, 8'd255, 10'd1020, 8'd255);
        vecs[2] = mk(8'd1,   8'd1,   8'd1,   8'd2,   10'd5,    8'd1);
        vecs[3] = mk(8'd1,   8'd2,   8'd2,   8'd2,   10'd7,    8'd2);
        vecs[4] = mk(8'd0,   8'd0,   8'd0,   8'd0,   10'd0,    8'd0);
        vecs[5] = mk(8'd0,   8'd0,   8'd0,   8'd1,   10'd1,    8'd0);
        vecs[6] = mk(8'd0,   8'd0,   8'd0,   8'd2,   10'd2,    8'd1);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_sum", {22'd0, out_sum}, 32'd0);
        chk("rst_mean", {24'd0, out_mean}, 32'd0);

        // Single windows with a gap between them.
        for (int v = 0; v < 7; v++) begin
            for (int j = 0; j < 4; j++) begin
                feed(vecs[v].px[j]);
            end
            expect_result($sformatf("vec%0d", v), vecs[v].sum, vecs[v].mean);
        end

        // Back-pressure then simultaneous transfer and accept.
        out_ready = 1'b0;
        for (int j = 0; j < 4; j++) feed(8'd8);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_pixel = 8'd3;
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_sum", {22'd0, out_sum}, 32'd32);
            chk("bp_mean", {24'd0, out_mean}, 32'd8);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        chk("bp_release_valid", {31'd0, out_valid}, 32'd1);
        for (int j = 0; j < 3; j++) feed(8'd5);
        expect_result("bp_next", 10'd18, 8'd5);

        // Continuous stream 0..11: results must appear with no bubble.
        begin
            logic [9:0] exp_sum [3];
            logic [7:0] exp_mean [3];
            exp_sum[0] = 10'd6;  exp_mean[0] = 8'd2;
            exp_sum[1] = 10'd22; exp_mean[1] = 8'd6;
            exp_sum[2] = 10'd38; exp_mean[2] = 8'd10;
            for (int i = 0; i <= 12; i++) begin
                @(negedge clk);
                if (i >= 4 && (i % 4) == 0) begin
                    chk("stream_valid", {31'd0, out_valid}, 32'd1);
                    chk("stream_sum", {22'd0, out_sum}, {22'd0, exp_sum[i/4-1]});
                    chk("stream_mean", {24'd0, out_mean}, {24'd0, exp_mean[i/4-1]});
                end else if (i > 0) begin
                    chk("stream_gap", {31'd0, out_valid}, 32'd0);
                end
                in_valid = (i < 12);
                in_pixel = 8'(i);
            end
            @(negedge clk);
            chk("stream_end", {31'd0, out_valid}, 32'd0);
        end

        // Clear mid-window discards the partial sum.
        feed(8'd50);
        feed(8'd60);
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        for (int j = 0; j < 4; j++) feed(8'd4);
        expect_result("clear", 10'd16, 8'd4);

        // Asynchronous reset mid-window.
        feed(8'd7);
        feed(8'd7);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_win_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_win_sum", {22'd0, out_sum}, 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Asynchronous reset while a result is pending.
        out_ready = 1'b0;
        feed(8'd1); feed(8'd2); feed(8'd3); feed(8'd4);
        @(negedge clk);
        in_valid = 1'b0;
        chk("pend_valid", {31'd0, out_valid}, 32'd1);
        chk("pend_sum", {22'd0, out_sum}, 32'd10);
        chk("pend_mean", {24'd0, out_mean}, 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_sum", {22'd0, out_sum}, 32'd0);
        chk("arst_out_mean", {24'd0, out_mean}, 32'd0);
        chk("arst_out_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) feed(8'd9);
        expect_result("post_rst", 10'd36, 8'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
